// File: rtl/nts_dispatcher.sv
// RX frame dispatcher: captures MAC frames into two ping-pong word buffers and
// presents completed frames to the NTS engine through a FWFT FIFO-style port.
module nts_dispatcher #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        i_clk,
    input  logic        i_areset_n,
    input  logic [7:0]  i_rx_data_valid,
    input  logic [63:0] i_rx_data,
    input  logic        i_rx_bad_frame,
    input  logic        i_rx_good_frame,
    output logic        o_dispatch_packet_available,
    input  logic        i_dispatch_packet_read_discard,
    output logic [7:0]  o_dispatch_data_valid,
    output logic        o_dispatch_fifo_empty,
    input  logic        i_dispatch_fifo_rd_en,
    output logic [63:0] o_dispatch_fifo_rd_data,
    output logic [31:0] o_counter_frames_accepted,
    output logic [31:0] o_counter_frames_dropped
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {B_EMPTY, B_WRITING, B_FULL, B_READING} buf_st_e;
    typedef enum logic [1:0] {W_IDLE, W_RECEIVE, W_DROP} wr_st_e;

    buf_st_e               buf_st_q [2];
    buf_st_e               buf_st_d [2];
    logic [ADDR_WIDTH:0]   cnt_q [2];
    logic [ADDR_WIDTH:0]   cnt_d [2];
    logic [7:0]            ldv_q [2];
    logic [7:0]            ldv_d [2];
    wr_st_e                wr_st_q, wr_st_d;
    logic                  wr_buf_q, wr_buf_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_dv_q, wr_dv_d;
    logic                  oldest_q, oldest_d;
    logic                  rd_act_q, rd_act_d;
    logic                  rd_buf_q, rd_buf_d;
    logic [ADDR_WIDTH:0]   rd_addr_q, rd_addr_d;
    logic [31:0]           acc_q, acc_d, drp_q, drp_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [63:0]           mem0 [DEPTH];
    logic [63:0]           mem1 [DEPTH];
    logic [63:0]           ram0_q, ram1_q;
    logic                  rx_word, fifo_empty;

    assign rx_word    = |i_rx_data_valid;
    assign fifo_empty = !rd_act_q || (rd_addr_q == cnt_q[rd_buf_q]);

    always_comb begin
        buf_st_d  = buf_st_q;
        cnt_d     = cnt_q;
        ldv_d     = ldv_q;
        wr_st_d   = wr_st_q;
        wr_buf_d  = wr_buf_q;
        wr_addr_d = wr_addr_q;
        wr_dv_d   = wr_dv_q;
        oldest_d  = oldest_q;
        rd_act_d  = rd_act_q;
        rd_buf_d  = rd_buf_q;
        rd_addr_d = rd_addr_q;
        acc_d     = acc_q;
        drp_d     = drp_q;
        mem_we    = 1'b0;
        mem_waddr = '0;

        case (wr_st_q)
            W_IDLE: begin
                if (rx_word) begin
                    if (buf_st_q[0] == B_EMPTY || buf_st_q[1] == B_EMPTY) begin
                        wr_buf_d           = (buf_st_q[0] != B_EMPTY);
                        buf_st_d[wr_buf_d] = B_WRITING;
                        mem_we             = 1'b1;
                        wr_addr_d          = '0;
                        wr_dv_d            = i_rx_data_valid;
                        wr_st_d            = W_RECEIVE;
                    end else begin
                        wr_st_d = W_DROP;
                    end
                end
            end
            W_RECEIVE: begin
                if (i_rx_good_frame) begin
                    buf_st_d[wr_buf_q] = B_FULL;
                    cnt_d[wr_buf_q]    = {1'b0, wr_addr_q} + (ADDR_WIDTH+1)'(1);
                    ldv_d[wr_buf_q]    = wr_dv_q;
                    // the other buffer still waiting means it was committed first
                    oldest_d = (buf_st_q[!wr_buf_q] == B_FULL) ? !wr_buf_q : wr_buf_q;
                    acc_d    = acc_q + 32'd1;
                    wr_st_d  = W_IDLE;
                end else if (i_rx_bad_frame) begin
                    buf_st_d[wr_buf_q] = B_EMPTY;
                    drp_d   = drp_q + 32'd1;
                    wr_st_d = W_IDLE;
                end else if (rx_word) begin
                    if (&wr_addr_q) begin
                        buf_st_d[wr_buf_q] = B_EMPTY;
                        wr_st_d = W_DROP;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = wr_addr_q + ADDR_WIDTH'(1);
                        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                        wr_dv_d   = i_rx_data_valid;
                    end
                end
            end
            W_DROP: begin
                if (i_rx_good_frame || i_rx_bad_frame) begin
                    drp_d   = drp_q + 32'd1;
                    wr_st_d = W_IDLE;
                end
            end
            default: wr_st_d = W_IDLE;
        endcase

        if (rd_act_q) begin
            if (i_dispatch_packet_read_discard) begin
                buf_st_d[rd_buf_q] = B_EMPTY;
                rd_act_d  = 1'b0;
                rd_addr_d = '0;
            end else if (i_dispatch_fifo_rd_en && !fifo_empty) begin
                rd_addr_d = rd_addr_q + (ADDR_WIDTH+1)'(1);
            end
        end else if (buf_st_q[0] == B_FULL || buf_st_q[1] == B_FULL) begin
            if (buf_st_q[0] == B_FULL && buf_st_q[1] == B_FULL)
                rd_buf_d = oldest_q;
            else
                rd_buf_d = (buf_st_q[1] == B_FULL);
            buf_st_d[rd_buf_d] = B_READING;
            rd_act_d  = 1'b1;
            rd_addr_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            buf_st_q[0] <= B_EMPTY;
            buf_st_q[1] <= B_EMPTY;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            ldv_q[0]    <= '0;
            ldv_q[1]    <= '0;
            wr_st_q     <= W_IDLE;
            wr_buf_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_dv_q     <= '0;
            oldest_q    <= 1'b0;
            rd_act_q    <= 1'b0;
            rd_buf_q    <= 1'b0;
            rd_addr_q   <= '0;
            acc_q       <= '0;
            drp_q       <= '0;
        end else begin
            buf_st_q  <= buf_st_d;
            cnt_q     <= cnt_d;
            ldv_q     <= ldv_d;
            wr_st_q   <= wr_st_d;
            wr_buf_q  <= wr_buf_d;
            wr_addr_q <= wr_addr_d;
            wr_dv_q   <= wr_dv_d;
            oldest_q  <= oldest_d;
            rd_act_q  <= rd_act_d;
            rd_buf_q  <= rd_buf_d;
            rd_addr_q <= rd_addr_d;
            acc_q     <= acc_d;
            drp_q     <= drp_d;
        end
    end

    // Reading at the next address keeps the RAM output aligned with rd_addr_q (FWFT).
    always_ff @(posedge i_clk) begin
        if (mem_we && !wr_buf_d) mem0[mem_waddr] <= i_rx_data;
        if (mem_we && wr_buf_d)  mem1[mem_waddr] <= i_rx_data;
        ram0_q <= mem0[rd_addr_d[ADDR_WIDTH-1:0]];
        ram1_q <= mem1[rd_addr_d[ADDR_WIDTH-1:0]];
    end

    assign o_dispatch_packet_available = rd_act_q;
    assign o_dispatch_data_valid       = rd_act_q ? ldv_q[rd_buf_q] : 8'h00;
    assign o_dispatch_fifo_empty       = fifo_empty;
    assign o_dispatch_fifo_rd_data     = rd_act_q ? (rd_buf_q ? ram1_q : ram0_q) : 64'h0;
    assign o_counter_frames_accepted   = acc_q;
    assign o_counter_frames_dropped    = drp_q;
endmodule
